// File: rtl/softmax_pkg.sv
// Shared constants and state encoding for the softmax exp scheduler.
// DATA_W/VEC_LEN here are the defaults the block parameters pick up.
package softmax_pkg;
  localparam int SM_DATA_W  = 16;
  localparam int SM_VEC_LEN = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } state_t;

  // Most negative exp argument magnitude: symmetric range, never the min code.
  function automatic int arg_sat_lim(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  localparam int SM_ARG_LIM = arg_sat_lim(SM_DATA_W);
endpackage

// File: rtl/softmax_vec_buf.sv
// Element buffer: one synchronous write port, one asynchronous read port.
module softmax_vec_buf
  import softmax_pkg::*;
#(
  parameter int DEPTH = SM_VEC_LEN,
  parameter int W     = SM_DATA_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/softmax_exp_sched.sv
// Softmax exp scheduler: loads a vector, tracks its max, sends (x - max)
// to an external exp unit one element at a time, then streams results out.
module softmax_exp_sched
  import softmax_pkg::*;
#(
  parameter int DATA_W  = SM_DATA_W,
  parameter int VEC_LEN = SM_VEC_LEN,
  parameter int SUM_W   = DATA_W + 4
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [3:0]        len_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [DATA_W-1:0] exp_arg_o,
  output logic              exp_req_o,
  input  logic [DATA_W-1:0] exp_res_i,
  input  logic              exp_res_valid_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [SUM_W-1:0]  out_sum_o,
  output logic              busy_o,
  output logic              done_o
);
  localparam int IDX_W = $clog2(VEC_LEN);
  localparam logic signed [DATA_W:0] ARG_MIN = (DATA_W + 1)'(-arg_sat_lim(DATA_W));

  state_t                   state, state_nxt;
  logic [IDX_W-1:0]         cnt, len_m1, len_m1_in;
  logic signed [DATA_W-1:0] max_val;
  logic [SUM_W-1:0]         acc;
  logic [SUM_W:0]           acc_sum;
  logic [DATA_W-1:0]        rd_data, wr_data, arg_sat;
  logic signed [DATA_W:0]   diff;
  logic                     wr_en, last;

  // One index serves load, issue/writeback and drain; phases never overlap.
  softmax_vec_buf #(.DEPTH(VEC_LEN), .W(DATA_W)) u_buf (
    .clk   (clock_i),
    .we    (wr_en),
    .waddr (cnt),
    .wdata (wr_data),
    .raddr (cnt),
    .rdata (rd_data)
  );

  always_comb begin
    int l;
    l = int'(len_i);
    if (l == 0) l = 1;
    if (l > VEC_LEN) l = VEC_LEN;
    len_m1_in = IDX_W'(l - 1);
  end

  assign last    = (cnt == len_m1);
  assign wr_en   = (state == S_LOAD && in_valid_i) || (state == S_WAIT && exp_res_valid_i);
  assign wr_data = (state == S_LOAD) ? in_data_i : exp_res_i;
  assign acc_sum = {1'b0, acc} + (SUM_W + 1)'(exp_res_i);

  // x - max is never positive; only the lower bound needs clamping.
  always_comb begin
    diff    = $signed({rd_data[DATA_W-1], rd_data}) - $signed({max_val[DATA_W-1], max_val});
    arg_sat = (diff < ARG_MIN) ? DATA_W'(ARG_MIN) : diff[DATA_W-1:0];
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state   <= S_IDLE;
      cnt     <= '0;
      len_m1  <= '0;
      max_val <= '0;
      acc     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (start_i) begin
          len_m1 <= len_m1_in;
          cnt    <= '0;
          acc    <= '0;
        end
        S_LOAD: if (in_valid_i) begin
          if (cnt == '0 || $signed(in_data_i) > max_val) max_val <= in_data_i;
          cnt <= last ? '0 : cnt + 1'b1;
        end
        S_WAIT: if (exp_res_valid_i) begin
          acc <= acc_sum[SUM_W] ? '1 : acc_sum[SUM_W-1:0];
          cnt <= last ? '0 : cnt + 1'b1;
        end
        S_DRAIN: if (out_ready_i) cnt <= last ? '0 : cnt + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_i) state_nxt = S_LOAD;
      S_LOAD:  if (in_valid_i && last) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (exp_res_valid_i) state_nxt = last ? S_DRAIN : S_ISSUE;
      S_DRAIN: if (out_ready_i && last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (state == S_LOAD);
    exp_req_o   = (state == S_ISSUE);
    exp_arg_o   = (state == S_ISSUE) ? arg_sat : '0;
    out_valid_o = (state == S_DRAIN);
    out_data_o  = (state == S_DRAIN) ? rd_data : '0;
    out_sum_o   = acc;
    busy_o      = (state != S_IDLE);
    done_o      = (state == S_DONE);
  end
endmodule

// File: tb/tb_softmax_exp_sched.sv
// Bench: table vectors, random vectors and reset/stall sequences against a
// behavioural exp-unit model; a second instance with SUM_W=17 checks saturation.
module tb_softmax_exp_sched;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, in_valid, out_ready, exp_res_valid;
  logic [3:0]  len_i;
  logic [15:0] in_data, exp_res;
  logic        in_ready_a, exp_req_a, out_valid_a, busy_a, done_a;
  logic [15:0] exp_arg_a, out_data_a;
  logic [19:0] out_sum_a;
  logic        in_ready_b, exp_req_b, out_valid_b, busy_b, done_b;
  logic [15:0] exp_arg_b, out_data_b;
  logic [16:0] out_sum_b;

  softmax_exp_sched #(.DATA_W(16), .VEC_LEN(10), .SUM_W(20)) dut_a (
    .clock_i(clk), .reset_i(rst), .start_i(start), .len_i(len_i),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready_a),
    .exp_arg_o(exp_arg_a), .exp_req_o(exp_req_a),
    .exp_res_i(exp_res), .exp_res_valid_i(exp_res_valid),
    .out_data_o(out_data_a), .out_valid_o(out_valid_a), .out_ready_i(out_ready),
    .out_sum_o(out_sum_a), .busy_o(busy_a), .done_o(done_a));

  softmax_exp_sched #(.DATA_W(16), .VEC_LEN(10), .SUM_W(17)) dut_b (
    .clock_i(clk), .reset_i(rst), .start_i(start), .len_i(len_i),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready_b),
    .exp_arg_o(exp_arg_b), .exp_req_o(exp_req_b),
    .exp_res_i(exp_res), .exp_res_valid_i(exp_res_valid),
    .out_data_o(out_data_b), .out_valid_o(out_valid_b), .out_ready_i(out_ready),
    .out_sum_o(out_sum_b), .busy_o(busy_b), .done_o(done_b));

  int n_chk = 0, n_fail = 0;
  int lat = 1, spur_cnt = 0, dbl_req = 0;
  bit ones = 1'b0;
  logic [15:0] arg_q[$];

  typedef struct {
    string             tag;
    logic [3:0]        len;
    int                n;
    logic [15:0][15:0] vals;
    logic [15:0][15:0] args;
    int                stall;
    int                lat;
    bit                ones;
  } vec_t;
  vec_t tbl[6];

  function automatic vec_t mk(input string t, input logic [3:0] len, input int n,
                              input int st, input int l, input bit o);
    vec_t v;
    v.tag = t; v.len = len; v.n = n; v.vals = '0; v.args = '0;
    v.stall = st; v.lat = l; v.ones = o;
    return v;
  endfunction

  // Behavioural exp: roughly 2^-(|arg|/256) scaled to 0xFFFF.
  function automatic logic [15:0] expf(input logic [15:0] a);
    int mag, sh;
    mag = -int'($signed(a));
    sh  = mag / 256;
    return (sh > 15) ? 16'h0 : 16'(32'hFFFF >> sh);
  endfunction

  function automatic logic [15:0] ref_arg(input logic [15:0] v, input logic [15:0] m);
    int d;
    d = int'($signed(v)) - int'($signed(m));
    if (d < -32767) d = -32767;
    return 16'(d);
  endfunction

  function automatic longint sat(input longint s, input int w);
    longint lim;
    lim = (longint'(1) << w) - 1;
    return (s > lim) ? lim : s;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    chk(name, {in_ready_a, exp_req_a, exp_arg_a, out_valid_a, out_data_a,
               out_sum_a, busy_a, done_a}, 64'h0);
  endtask

  // Exp unit model: one result lat cycles after each request; also injects
  // a stray result whenever spur_cnt is bumped.
  initial begin : exp_model
    int seen, pend;
    logic [15:0] a;
    seen = 0; pend = 0; a = '0;
    exp_res_valid = 1'b0; exp_res = '0;
    forever begin
      @(negedge clk);
      exp_res_valid = 1'b0;
      if (pend > 0) begin
        if (exp_req_a) dbl_req++;
        pend--;
        if (pend == 0) begin
          exp_res = ones ? 16'hFFFF : expf(a);
          exp_res_valid = 1'b1;
        end
      end else if (spur_cnt != seen) begin
        seen = spur_cnt;
        exp_res = 16'hA5A5;
        exp_res_valid = 1'b1;
      end else if (exp_req_a && !rst) begin
        a = exp_arg_a;
        arg_q.push_back(a);
        pend = lat;
      end
    end
  end

  task automatic load_vec(input string tag, input logic [3:0] len, input int n,
                          input logic [15:0][15:0] vals);
    int i, g;
    @(negedge clk); start = 1'b1; len_i = len;
    @(negedge clk); start = 1'b0;
    chk({tag, "_busy"}, busy_a, 1);
    chk({tag, "_in_ready"}, in_ready_a, 1);
    i = 0; g = 0;
    while (i < n && g < 500) begin
      if ($urandom_range(3) == 0) in_valid = 1'b0;
      else begin
        in_valid = 1'b1;
        in_data  = vals[i];
        if (in_ready_a) i++;
      end
      start = 1'($urandom_range(1));
      len_i = 4'($urandom_range(15));
      @(negedge clk); g++;
    end
    in_valid = 1'b0; start = 1'b0;
    chk({tag, "_loaded"}, i, n);
    chk({tag, "_in_ready_drop"}, in_ready_a, 0);
    chk({tag, "_issue"}, exp_req_a, 1);
  endtask

  task automatic run_vec(input string tag, input logic [3:0] len, input int n,
                         input logic [15:0][15:0] vals, input logic [15:0][15:0] args,
                         input int stall_at, input int l, input bit one);
    logic [15:0] res [16];
    logic [15:0] held;
    longint sum;
    int base, dbase, got, g, stall_cnt;
    bit did_stall, was_stalled, sum_done;
    lat = l; ones = one;
    base = arg_q.size(); dbase = dbl_req;
    sum = 0;
    for (int k = 0; k < n; k++) begin
      res[k] = one ? 16'hFFFF : expf(args[k]);
      sum += longint'(res[k]);
    end
    load_vec(tag, len, n, vals);
    out_ready = 1'b0;
    got = 0; g = 0; stall_cnt = 0; held = '0;
    did_stall = 0; was_stalled = 0; sum_done = 0;
    while (got < n && g < 3000) begin
      @(negedge clk); g++;
      if (out_valid_a) begin
        if (!sum_done) begin
          chk({tag, "_sum20"}, out_sum_a, sat(sum, 20));
          chk({tag, "_sum17"}, out_sum_b, sat(sum, 17));
          sum_done = 1;
        end
        if (was_stalled) chk({tag, "_stable"}, out_data_a, held);
        if (got == stall_at && !did_stall) begin did_stall = 1; stall_cnt = 4; end
        if (stall_cnt > 0) begin out_ready = 1'b0; stall_cnt--; end
        else out_ready = (stall_at >= 0) ? 1'b1 : ($urandom_range(3) != 0);
        if (out_ready) begin
          chk({tag, "_out"}, out_data_a, res[got]);
          chk({tag, "_out_b"}, out_data_b, res[got]);
          got++;
          was_stalled = 0;
        end else begin
          was_stalled = 1;
          held = out_data_a;
        end
      end else begin
        out_ready = 1'($urandom_range(1));
      end
    end
    chk({tag, "_nout"}, got, n);
    @(negedge clk); out_ready = 1'b0;
    chk({tag, "_done"}, {done_a, out_valid_a, busy_a}, 3'b101);
    @(negedge clk);
    chk({tag, "_idle"}, {done_a, busy_a}, 2'b00);
    chk({tag, "_nreq"}, arg_q.size() - base, n);
    for (int k = 0; k < n && base + k < arg_q.size(); k++)
      chk({tag, "_arg"}, arg_q[base + k], args[k]);
    chk({tag, "_one_outstanding"}, dbl_req - dbase, 0);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    rst = 1'b1; start = 1'b0; len_i = '0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;

    tbl[0] = mk("len3", 4'd3, 3, -1, 5, 1'b0);
    tbl[0].vals[0] = 16'h0100; tbl[0].vals[1] = 16'h0000; tbl[0].vals[2] = 16'hFF00;
    tbl[0].args[0] = 16'h0000; tbl[0].args[1] = 16'hFF00; tbl[0].args[2] = 16'hFE00;
    tbl[1] = mk("satarg", 4'd2, 2, -1, 2, 1'b0);
    tbl[1].vals[0] = 16'h7FFF; tbl[1].vals[1] = 16'h8000;
    tbl[1].args[0] = 16'h0000; tbl[1].args[1] = 16'h8001;
    tbl[2] = mk("len0", 4'd0, 1, -1, 1, 1'b0);
    tbl[2].vals[0] = 16'h1234;
    tbl[3] = mk("len15", 4'd15, 10, -1, 3, 1'b0);
    for (int k = 0; k < 10; k++) tbl[3].vals[k] = 16'h0050;
    tbl[4] = mk("stall", 4'd6, 6, 2, 1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      tbl[4].vals[k] = 16'(16 * (k + 1));
      tbl[4].args[k] = 16'(16 * (k - 5));
    end
    tbl[5] = mk("ones", 4'd10, 10, -1, 2, 1'b1);

    repeat (3) @(negedge clk);
    chk_zero("reset_outputs");
    rst = 1'b0;
    @(negedge clk);
    chk_zero("idle_after_reset");

    foreach (tbl[t])
      run_vec(tbl[t].tag, tbl[t].len, tbl[t].n, tbl[t].vals, tbl[t].args,
              tbl[t].stall, tbl[t].lat, tbl[t].ones);

    for (int r = 0; r < 10; r++) begin : rnd
      logic [3:0] lr;
      logic [15:0][15:0] v, a;
      logic [15:0] mx;
      int n;
      lr = 4'($urandom_range(15));
      n = (lr == 0) ? 1 : ((int'(lr) > 10) ? 10 : int'(lr));
      v = '0; a = '0;
      for (int k = 0; k < 16; k++)
        v[k] = (r % 3 == 0) ? 16'($urandom) : 16'($urandom_range(2047)) - 16'd1024;
      mx = v[0];
      for (int k = 1; k < n; k++) if ($signed(v[k]) > $signed(mx)) mx = v[k];
      for (int k = 0; k < n; k++) a[k] = ref_arg(v[k], mx);
      run_vec("rand", lr, n, v, a, -1, 1 + (r % 4), 1'b0);
    end

    // Reset while waiting on the exp unit, then a late and a stray result.
    lat = 5; ones = 1'b0;
    load_vec("rstwait", tbl[0].len, tbl[0].n, tbl[0].vals);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("rst_in_wait");
    spur_cnt++;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk_zero("idle_ignores_res");
    end
    run_vec("after_rst", tbl[0].len, tbl[0].n, tbl[0].vals, tbl[0].args, -1, 5, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
